pc_gen: RTL and testbench

- Parametrised program-counter generator for the fetch stage; next generation of the single-width PC register.
- Adds:
  - configurable address width, reset vector and instruction step;
  - a valid/ready fetch handshake toward instruction memory;
  - branch/jump redirect from EX;
  - a one-deep pending-redirect buffer, so redirects arriving during a stall are not lost.
- Sits between the stall controller, EX (redirect source) and the IF/ID instruction-memory port.

---
 rtl/pc_gen.sv | 152 +++++++++++++++
 tb/tb_pc_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with a valid/ready fetch handshake and a one-deep buffer for redirects that arrive during a stall.
// Define PC_GEN_PERF_EN to add the fetch_cnt/redir_cnt performance counters.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                STALL_W   = 6
`ifdef PC_GEN_PERF_EN
  ,
  parameter int                CNT_W     = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_target,
  input  logic               fetch_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               fetch_valid,
  output logic               redir_pending,
  output logic               misalign
`ifdef PC_GEN_PERF_EN
  ,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   redir_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

  typedef enum logic [0:0] {
    OFF = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic                ce_r;
  logic                pend_valid_r;
  logic [ADDR_W-1:0]   pend_target_r;
  logic                misalign_r;

  logic                accept_s;
  logic                apply_s;
  logic [ADDR_W-1:0]   apply_target_s;
  logic                unused_stall;

  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
    return t & ~ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
    return |(t & ALIGN_MASK);
  endfunction

  assign unused_stall  = ^stall;
  assign fetch_valid   = ce_r & ~stall[0];
  assign accept_s      = fetch_valid & fetch_ready;
  assign pc            = pc_r;
  assign ce            = ce_r;
  assign redir_pending = pend_valid_r;
  assign misalign      = misalign_r;

  // Select the redirect applied this edge: a live redirect beats the buffered one.
  always_comb begin
    apply_s        = 1'b0;
    apply_target_s = redir_target;
    if ((state_r == RUN) && !stall[0]) begin
      if (redir_valid) begin
        apply_s        = 1'b1;
        apply_target_s = redir_target;
      end else if (pend_valid_r) begin
        apply_s        = 1'b1;
        apply_target_s = pend_target_r;
      end else begin
        apply_s        = 1'b0;
        apply_target_s = redir_target;
      end
    end else begin
      apply_s        = 1'b0;
      apply_target_s = redir_target;
    end
  end

  // Control FSM, PC register and pending-redirect buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= OFF;
      pc_r          <= RESET_VEC;
      ce_r          <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
      misalign_r    <= 1'b0;
    end else begin
      case (state_r)
        OFF: begin
          state_r <= RUN;
          ce_r    <= 1'b1;
          pc_r    <= RESET_VEC;
        end
        RUN: begin
          ce_r <= 1'b1;
          if (stall[0]) begin
            if (redir_valid) begin
              pend_valid_r  <= 1'b1;
              pend_target_r <= redir_target;
            end
          end else if (apply_s) begin
            pc_r         <= align_target(apply_target_s);
            misalign_r   <= is_misaligned(apply_target_s);
            pend_valid_r <= 1'b0;
          end else if (accept_s) begin
            pc_r <= pc_r + STEP_INC;
          end
        end
        default: begin
          state_r      <= OFF;
          ce_r         <= 1'b0;
          pc_r         <= RESET_VEC;
          pend_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_GEN_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_r;
  logic [CNT_W-1:0] redir_cnt_r;

  assign fetch_cnt = fetch_cnt_r;
  assign redir_cnt = redir_cnt_r;

  // Free-running, silently wrapping event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_r <= '0;
      redir_cnt_r <= '0;
    end else begin
      if (accept_s) begin
        fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
      end
      if (apply_s) begin
        redir_cnt_r <= redir_cnt_r + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: a default 32-bit instance plus an 8-bit instance for the wrap case.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'd0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic        fetch_ready = 1'b1;
  logic [31:0] pc;
  logic        ce;
  logic        fetch_valid;
  logic        redir_pending;
  logic        misalign;
`ifdef PC_GEN_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redir_cnt;
`endif

  logic        rst8 = 1'b0;
  logic [7:0]  pc8;
  logic        ce8;
  logic        fetch_valid8;
  logic        redir_pending8;
  logic        misalign8;
`ifdef PC_GEN_PERF_EN
  logic [31:0] fetch_cnt8;
  logic [31:0] redir_cnt8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .fetch_ready  (fetch_ready),
    .pc           (pc),
    .ce           (ce),
    .fetch_valid  (fetch_valid),
    .redir_pending(redir_pending),
    .misalign     (misalign)
`ifdef PC_GEN_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .redir_cnt    (redir_cnt)
`endif
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF0)) u_dut8 (
    .clk          (clk),
    .rst          (rst8),
    .stall        (6'd0),
    .redir_valid  (1'b0),
    .redir_target (8'h00),
    .fetch_ready  (1'b1),
    .pc           (pc8),
    .ce           (ce8),
    .fetch_valid  (fetch_valid8),
    .redir_pending(redir_pending8),
    .misalign     (misalign8)
`ifdef PC_GEN_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt8),
    .redir_cnt    (redir_cnt8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle to the following falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_ce", 32'(ce), 32'h0);
    check("rst_fv", 32'(fetch_valid), 32'h0);
    check("rst_pend", 32'(redir_pending), 32'h0);
    check("rst_mis", 32'(misalign), 32'h0);

    rst = 1'b1;
    step();
    check("first_ce", 32'(ce), 32'h1);
    check("first_pc", pc, 32'h0);
    step(); check("seq_4", pc, 32'h4);
    step(); check("seq_8", pc, 32'h8);
    step(); check("seq_c", pc, 32'hC);
    step(); check("seq_10", pc, 32'h10);

    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_pc", pc, 32'h10);
      check("bp_fv", 32'(fetch_valid), 32'h1);
    end
    fetch_ready = 1'b1;
    step(); check("bp_rel", pc, 32'h14);
    step(); step(); step();
    check("at_20", pc, 32'h20);

    redir_valid = 1'b1; redir_target = 32'h100;
    step();
    redir_valid = 1'b0;
    check("redir_pc", pc, 32'h100);
    check("redir_mis", 32'(misalign), 32'h0);

    stall = 6'b000001;
    #1 check("stall_fv", 32'(fetch_valid), 32'h0);
    redir_valid = 1'b1; redir_target = 32'h200;
    step();
    check("stall_pc1", pc, 32'h100);
    check("stall_pend1", 32'(redir_pending), 32'h1);
    redir_target = 32'h300;
    step();
    redir_valid = 1'b0;
    check("stall_pc2", pc, 32'h100);
    step();
    check("stall_pc3", pc, 32'h100);
    check("stall_pend3", 32'(redir_pending), 32'h1);
    stall = 6'd0;
    step();
    check("release_pc", pc, 32'h300);
    check("release_pend", 32'(redir_pending), 32'h0);
    step(); check("after_rel", pc, 32'h304);

    redir_valid = 1'b1; redir_target = 32'h102;
    step();
    redir_valid = 1'b0;
    check("mis_pc", pc, 32'h100);
    check("mis_set", 32'(misalign), 32'h1);
    step();
    check("mis_inc_pc", pc, 32'h104);
    check("mis_hold", 32'(misalign), 32'h1);
    redir_valid = 1'b1; redir_target = 32'h400;
    step();
    redir_valid = 1'b0;
    check("mis_clr_pc", pc, 32'h400);
    check("mis_clr", 32'(misalign), 32'h0);

    stall = 6'b000001; redir_valid = 1'b1; redir_target = 32'h500;
    step();
    check("both_pend", 32'(redir_pending), 32'h1);
    stall = 6'd0; redir_target = 32'h600;
    step();
    redir_valid = 1'b0;
    check("both_pc", pc, 32'h600);
    check("both_pend_clr", 32'(redir_pending), 32'h0);
    step(); check("both_next", pc, 32'h604);

    #2 rst = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_ce", 32'(ce), 32'h0);
    @(negedge clk);
    redir_valid = 1'b1; redir_target = 32'h700;
    rst = 1'b1;
    step();
    redir_valid = 1'b0;
    check("off_redir_pc", pc, 32'h0);
    check("off_ce", 32'(ce), 32'h1);
    for (int i = 0; i < 5; i++) step();
    check("perf_pc", pc, 32'h14);
    fetch_ready = 1'b0;
    redir_valid = 1'b1; redir_target = 32'h40;
    step();
    redir_target = 32'h80;
    step();
    redir_valid = 1'b0;
    check("perf_redir_pc", pc, 32'h80);
`ifdef PC_GEN_PERF_EN
    check("fetch_cnt", fetch_cnt, 32'd5);
    check("redir_cnt", redir_cnt, 32'd2);
`endif
    fetch_ready = 1'b1;

    rst8 = 1'b1;
    step(); check("w8_f0", 32'(pc8), 32'hF0);
    step(); step(); step();
    check("w8_fc", 32'(pc8), 32'hFC);
    step(); check("w8_wrap", 32'(pc8), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
